proj_output_stage: RTL



---
 rtl/proj_stage_pkg.sv | 27 ++
 rtl/sel_debounce.sv | 110 +++++++++++
 rtl/proj_output_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/proj_stage_pkg.sv
// ---------------------------------------------------------------------------
// proj_stage_pkg
//   Shared definitions for the project output stage that sits between the
//   16-bit project output mux and the Caravel user IO pads.
//
//   Contents:
//     SEL_W         default project-select width
//     NUM_PROJ      number of valid projects (higher selects map to 0)
//     BITS          default pad / mux data width
//     BLANK_OEB     pad output-enable-bar value while blanked (all pads off)
//     stage_state_t output-stage FSM states
// ---------------------------------------------------------------------------
package proj_stage_pkg;

   localparam int unsigned SEL_W    = 4;
   localparam int unsigned NUM_PROJ = 13;
   localparam int unsigned BITS     = 16;

   localparam logic [BITS-1:0] BLANK_OEB = '1;

   typedef enum logic [1:0] {
      ACTIVE   = 2'd0,
      DEBOUNCE = 2'd1,
      BLANK    = 2'd2
   } stage_state_t;

endpackage : proj_stage_pkg

// File: rtl/sel_debounce.sv
// ---------------------------------------------------------------------------
// sel_debounce
//   Debounces the host project-select request. A new select is accepted only
//   after it has been sampled unchanged for SEL_STABLE consecutive edges while
//   unlocked and different from the currently active project. The unit owns
//   the candidate select and its stability counter; the owning FSM state is
//   supplied by the parent so that requests are ignored while blanking.
//
//   Ports:
//     clk        system clock
//     rst        synchronous active-high reset
//     state      current output-stage FSM state
//     sel_lock   1 = ignore all select changes
//     sel_req    raw requested select (may glitch, may be out of range)
//     cur_sel    currently active (registered) select
//     sel_start  ACTIVE -> DEBOUNCE: a differing request was first seen
//     sel_abort  DEBOUNCE -> ACTIVE: request withdrawn or locked
//     sel_accept request held long enough; switch to sel_new this edge
//     sel_new    select to load when sel_accept is high
// ---------------------------------------------------------------------------
module sel_debounce #(
   parameter int unsigned SEL_W      = 4,
   parameter int unsigned NUM_PROJ   = 13,
   parameter int unsigned SEL_STABLE = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  proj_stage_pkg::stage_state_t state,
   input  logic                         sel_lock,
   input  logic [SEL_W-1:0]             sel_req,
   input  logic [SEL_W-1:0]             cur_sel,
   output logic                         sel_start,
   output logic                         sel_abort,
   output logic                         sel_accept,
   output logic [SEL_W-1:0]             sel_new
);

   import proj_stage_pkg::*;

   // deb_cnt only ever holds 1 .. SEL_STABLE-1
   localparam int unsigned CNT_W = (SEL_STABLE > 1) ? $clog2(SEL_STABLE) : 1;

   logic [SEL_W-1:0] nsel;
   logic [SEL_W-1:0] cand;
   logic [CNT_W-1:0] deb_cnt;
   logic             differs;
   logic             cnt_done;

   // Out-of-range project numbers fall back to project 0
   assign nsel     = (32'(sel_req) >= NUM_PROJ) ? '0 : sel_req;
   assign differs  = !sel_lock && (nsel != cur_sel);
   assign cnt_done = (deb_cnt == CNT_W'(SEL_STABLE - 1));

   always_comb begin
      sel_start  = 1'b0;
      sel_abort  = 1'b0;
      sel_accept = 1'b0;
      sel_new    = cand;
      case (state)
         ACTIVE: begin
            if (differs) begin
               if (SEL_STABLE == 1) begin
                  // A single stable sample is enough: accept straight away
                  sel_accept = 1'b1;
                  sel_new    = nsel;
               end else begin
                  sel_start = 1'b1;
               end
            end
         end
         DEBOUNCE: begin
            if (!differs) begin
               sel_abort = 1'b1;
            end else if ((nsel == cand) && cnt_done) begin
               sel_accept = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand    <= '0;
         deb_cnt <= '0;
      end else begin
         case (state)
            ACTIVE: begin
               if (differs) begin
                  cand    <= nsel;
                  deb_cnt <= CNT_W'(1);
               end
            end
            DEBOUNCE: begin
               if (differs) begin
                  if (nsel != cand) begin
                     // Request moved to yet another project: restart the count
                     cand    <= nsel;
                     deb_cnt <= CNT_W'(1);
                  end else if (!cnt_done) begin
                     deb_cnt <= deb_cnt + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule : sel_debounce

// File: rtl/proj_output_stage.sv
// ---------------------------------------------------------------------------
// proj_output_stage
//   Output stage between the project output mux and the Caravel user IO
//   pads. Debounces the host project select, drives the registered select
//   into the mux, blanks the pads (tri-stated, data zero) for BLANK_CYCLES
//   cycles on every project switch and after reset, and registers the
//   selected project's data onto the pads. Accepted switches are counted
//   (saturating) for debug.
//
//   Ports:
//     wb_clk_i      system clock
//     wb_rst_i      synchronous active-high reset
//     wbs_sel_i     requested project select (may glitch)
//     sel_lock      1 = ignore all select changes
//     mux_in        combinational output of the project mux
//     mux_sel       registered select driving the project mux
//     io_out        registered pad data
//     io_oeb        registered pad output-enable-bar (0 = driving)
//     switching     high while debouncing or blanking
//     switch_count  accepted switches, saturating at 255
// ---------------------------------------------------------------------------
module proj_output_stage #(
   parameter int unsigned BITS         = proj_stage_pkg::BITS,
   parameter int unsigned SEL_W        = proj_stage_pkg::SEL_W,
   parameter int unsigned NUM_PROJ     = proj_stage_pkg::NUM_PROJ,
   parameter int unsigned SEL_STABLE   = 4,
   parameter int unsigned BLANK_CYCLES = 3
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [SEL_W-1:0] wbs_sel_i,
   input  logic             sel_lock,
   input  logic [BITS-1:0]  mux_in,
   output logic [SEL_W-1:0] mux_sel,
   output logic [BITS-1:0]  io_out,
   output logic [BITS-1:0]  io_oeb,
   output logic             switching,
   output logic [7:0]       switch_count
);

   import proj_stage_pkg::*;

   localparam int unsigned BCNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

   stage_state_t      state;
   stage_state_t      next_state;
   logic [BCNT_W-1:0] blank_cnt;
   logic              blank_done;

   logic              sel_start;
   logic              sel_abort;
   logic              sel_accept;
   logic [SEL_W-1:0]  sel_new;

   sel_debounce #(
      .SEL_W      (SEL_W),
      .NUM_PROJ   (NUM_PROJ),
      .SEL_STABLE (SEL_STABLE)
   ) u_sel_debounce (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .state      (state),
      .sel_lock   (sel_lock),
      .sel_req    (wbs_sel_i),
      .cur_sel    (mux_sel),
      .sel_start  (sel_start),
      .sel_abort  (sel_abort),
      .sel_accept (sel_accept),
      .sel_new    (sel_new)
   );

   assign blank_done = (blank_cnt == BCNT_W'(BLANK_CYCLES - 1));

   always_comb begin
      next_state = state;
      case (state)
         ACTIVE: begin
            if (sel_accept) begin
               next_state = BLANK;
            end else if (sel_start) begin
               next_state = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (sel_abort) begin
               next_state = ACTIVE;
            end else if (sel_accept) begin
               next_state = BLANK;
            end
         end
         BLANK: begin
            if (blank_done) begin
               next_state = ACTIVE;
            end
         end
         default: next_state = BLANK;
      endcase
   end

   // Pads are decided from next_state so that the edge entering BLANK
   // already tri-states them and the edge leaving BLANK loads data from the
   // newly selected project (mux_sel changed BLANK_CYCLES edges earlier).
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= BLANK;
         blank_cnt    <= '0;
         mux_sel      <= '0;
         io_out       <= '0;
         io_oeb       <= '1;
         switching    <= 1'b1;
         switch_count <= '0;
      end else begin
         state <= next_state;

         if (sel_accept) begin
            mux_sel   <= sel_new;
            blank_cnt <= '0;
            if (switch_count != 8'hFF) begin
               switch_count <= switch_count + 8'd1;
            end
         end else if ((state == BLANK) && !blank_done) begin
            blank_cnt <= blank_cnt + BCNT_W'(1);
         end

         if (next_state == BLANK) begin
            io_out <= '0;
            io_oeb <= '1;
         end else begin
            io_out <= mux_in;
            io_oeb <= '0;
         end

         switching <= (next_state != ACTIVE);
      end
   end

endmodule : proj_output_stage
